fft_lane_serializer: RTL and testbench

FFT_LANE_SERIALIZER -- requirements
Module: fft_lane_serializer

---
 rtl/fft_lane_serializer.sv | 163 ++++++++++++++++
 tb/tb_fft_lane_serializer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_lane_serializer.sv
// fft_lane_serializer: packs LANES complex samples per write into a block-RAM
// ring buffer and streams them out one sample per cycle, first-word-fall-through,
// with frame-end marking, upstream clock-enable headroom and a sticky overflow.
// The buffer holds whole write words, so DEPTH_LOG2 must exceed log2(LANES).
module fft_lane_serializer #(
  parameter int WIDTH      = 11,
  parameter int LANES      = 2,
  parameter int DEPTH_LOG2 = 8,
  parameter int SLACK      = 8,
  parameter int FRAME      = 64
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     clr,
  input  logic                     wr_valid,
  input  logic [LANES*2*WIDTH-1:0] din,
  output logic                     ce,
  output logic                     full,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2*WIDTH-1:0]       dout,
  output logic                     out_last,
  output logic [DEPTH_LOG2:0]      level,
  output logic                     overflow
);

  localparam int SW      = 2 * WIDTH;
  localparam int WORDW   = LANES * SW;
  localparam int LGL     = (LANES > 1) ? $clog2(LANES) : 0;
  localparam int WAW     = DEPTH_LOG2 - LGL;
  localparam int NWORDS  = 1 << WAW;
  localparam int CAP     = 1 << DEPTH_LOG2;
  localparam int CE_ROOM = LANES * (SLACK + 1);
  localparam int FCW     = (FRAME > 1) ? $clog2(FRAME) : 1;
  localparam int LVLW    = DEPTH_LOG2 + 1;

  // Write side works in whole words, read side in single samples.
  logic                  armed_q;
  logic [WAW-1:0]        wrWord_q, wrWord_d;
  logic [DEPTH_LOG2-1:0] rdPtr_q, rdPtr_d;
  logic [LVLW-1:0]       level_q, level_d;
  logic                  full_q, full_d;
  logic                  ce_q, ce_d;
  logic                  overflow_q, overflow_d;
  logic [FCW-1:0]        frameCnt_q, frameCnt_d;

  logic                  wrAccept, wrDrop, rdAccept;
  int                    freeSlots;
  logic [WAW-1:0]        rdWord_d;
  logic                  collide;

  logic [WORDW-1:0]      mem [0:NWORDS-1];
  logic [WORDW-1:0]      ramWord_q;
  logic                  bypassSel_q;
  logic [WORDW-1:0]      bypassWord_q;
  logic [WORDW-1:0]      headWord;
  logic [DEPTH_LOG2-1:0] rdLane;
  logic [SW-1:0]         headSample;

  // Reset release is taken up by this flop so nothing is written on the release edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) armed_q <= 1'b0;
    else        armed_q <= 1'b1;
  end

  // Next-state for pointers, level, flags and frame counter; clr overrides traffic.
  always_comb begin
    wrAccept   = wr_valid && !full_q && armed_q && !clr;
    wrDrop     = wr_valid && full_q && !clr;
    rdAccept   = out_valid && out_ready && !clr;
    wrWord_d   = wrWord_q;
    rdPtr_d    = rdPtr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    frameCnt_d = frameCnt_q;
    if (clr) begin
      wrWord_d   = '0;
      rdPtr_d    = '0;
      level_d    = '0;
      overflow_d = 1'b0;
      frameCnt_d = '0;
    end else begin
      if (wrAccept) begin
        wrWord_d = wrWord_q + WAW'(1);
        level_d  = level_d + LVLW'(LANES);
      end
      if (rdAccept) begin
        rdPtr_d    = rdPtr_q + DEPTH_LOG2'(1);
        level_d    = level_d - LVLW'(1);
        frameCnt_d = (frameCnt_q == FCW'(FRAME - 1)) ? '0 : frameCnt_q + FCW'(1);
      end
      if (wrDrop) overflow_d = 1'b1;
    end
    freeSlots = CAP - int'(level_d);
    full_d    = freeSlots < LANES;
    ce_d      = freeSlots >= CE_ROOM;
    if (clr) begin
      full_d = 1'b0;
      ce_d   = 1'b1;
    end
  end

  // State registers; full and ce are registered from the post-update level.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wrWord_q   <= '0;
      rdPtr_q    <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      ce_q       <= 1'b1;
      overflow_q <= 1'b0;
      frameCnt_q <= '0;
    end else begin
      wrWord_q   <= wrWord_d;
      rdPtr_q    <= rdPtr_d;
      level_q    <= level_d;
      full_q     <= full_d;
      ce_q       <= ce_d;
      overflow_q <= overflow_d;
      frameCnt_q <= frameCnt_d;
    end
  end

  // The RAM is addressed with the next head word, so the head is ready right after each pop.
  assign rdWord_d = rdPtr_d[DEPTH_LOG2-1:LGL];
  assign collide  = wrAccept && (wrWord_q == rdWord_d);

  // Plain synchronous-read RAM without reset so it maps onto block RAM.
  always_ff @(posedge CLK) begin
    if (wrAccept) mem[wrWord_q] <= din;
    ramWord_q <= mem[rdWord_d];
  end

  // When the word being written becomes the head in the same cycle, the RAM returns
  // stale data, so the incoming word is captured alongside and selected instead.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      bypassSel_q  <= 1'b0;
      bypassWord_q <= '0;
    end else begin
      bypassSel_q <= collide;
      if (collide) bypassWord_q <= din;
    end
  end

  // Head sample selection (lane 0 sits in the MSBs) and output drive.
  always_comb begin
    headWord   = bypassSel_q ? bypassWord_q : ramWord_q;
    rdLane     = rdPtr_q & DEPTH_LOG2'(LANES - 1);
    headSample = '0;
    for (int k = 0; k < LANES; k++) begin
      if (rdLane == DEPTH_LOG2'(k)) headSample = headWord[(LANES-1-k)*SW +: SW];
    end
    out_valid = (level_q != '0);
    dout      = out_valid ? headSample : '0;
    out_last  = out_valid && (frameCnt_q == FCW'(FRAME - 1));
    level     = level_q;
    full      = full_q;
    ce        = ce_q;
    overflow  = overflow_q;
  end

endmodule

// File: tb/tb_fft_lane_serializer.sv
// Testbench for fft_lane_serializer: hand-derived vector table, directed
// stream/stall/reset sequences and random traffic against a queue model.
module tb_fft_lane_serializer;

  localparam int WIDTH      = 11;
  localparam int LANES      = 2;
  localparam int DEPTH_LOG2 = 4;
  localparam int SLACK      = 2;
  localparam int FRAME      = 64;
  localparam int SW         = 2 * WIDTH;
  localparam int DW         = LANES * SW;
  localparam int CAP        = 1 << DEPTH_LOG2;
  localparam int CE_ROOM    = LANES * (SLACK + 1);

  localparam logic [SW-1:0] A  = 22'h012345;
  localparam logic [SW-1:0] B  = 22'h023456;
  localparam logic [SW-1:0] C  = 22'h034567;
  localparam logic [SW-1:0] D  = 22'h045678;
  localparam logic [SW-1:0] N0 = 22'h200000;
  localparam logic [SW-1:0] N1 = 22'h200001;

  logic              CLK = 1'b0;
  logic              RST_N = 1'b0;
  logic              clr = 1'b0;
  logic              wr_valid = 1'b0;
  logic              out_ready = 1'b0;
  logic [DW-1:0]     din = '0;
  logic              ce, full, out_valid, out_last, overflow;
  logic [SW-1:0]     dout;
  logic [DEPTH_LOG2:0] level;

  fft_lane_serializer #(
    .WIDTH(WIDTH), .LANES(LANES), .DEPTH_LOG2(DEPTH_LOG2), .SLACK(SLACK), .FRAME(FRAME)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .clr(clr), .wr_valid(wr_valid), .din(din),
    .ce(ce), .full(full), .out_valid(out_valid), .out_ready(out_ready),
    .dout(dout), .out_last(out_last), .level(level), .overflow(overflow)
  );

  always #5 CLK = ~CLK;

  int vectorCount = 0;
  int miscompareCount = 0;

  typedef struct {
    logic          c;
    logic          w;
    logic [DW-1:0] d;
    logic          r;
    int            expLevel;
    logic          expValid;
    logic [SW-1:0] expDout;
    logic          expFull;
    logic          expCe;
    logic          expOvf;
  } vec_t;
  vec_t vecs[$];

  // Reference model: a plain sample queue plus the frame count and flags.
  logic [SW-1:0] mq[$];
  int            mCnt = 0;
  bit            mOvf = 1'b0;
  bit            mArmed = 1'b0;

  function automatic void modelReset();
    mq.delete();
    mCnt   = 0;
    mOvf   = 1'b0;
    mArmed = 1'b0;
  endfunction

  function automatic void modelStep(input logic c, input logic w, input logic [DW-1:0] d, input logic r);
    bit wasFull;
    wasFull = (CAP - mq.size()) < LANES;
    if (c) begin
      mq.delete();
      mCnt = 0;
      mOvf = 1'b0;
    end else begin
      if (r && mq.size() > 0) begin
        void'(mq.pop_front());
        mCnt = (mCnt + 1) % FRAME;
      end
      if (w && wasFull) mOvf = 1'b1;
      if (w && !wasFull && mArmed) begin
        for (int l = 0; l < LANES; l++) mq.push_back(d[(LANES-1-l)*SW +: SW]);
      end
    end
    mArmed = 1'b1;
  endfunction

  function automatic void addVec(input logic c, input logic w, input logic [DW-1:0] d, input logic r,
                                 input int lvl, input logic v, input logic [SW-1:0] od,
                                 input logic f, input logic e, input logic o);
    vec_t x;
    x.c = c; x.w = w; x.d = d; x.r = r;
    x.expLevel = lvl; x.expValid = v; x.expDout = od;
    x.expFull = f; x.expCe = e; x.expOvf = o;
    vecs.push_back(x);
  endfunction

  function automatic logic [SW-1:0] sVal(input int base, input int i);
    return SW'(base + i);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectorCount++;
    if (act !== exp) begin
      miscompareCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic c, input logic w, input logic [DW-1:0] d, input logic r);
    clr = c; wr_valid = w; din = d; out_ready = r;
    @(posedge CLK);
    modelStep(c, w, d, r);
    #1;
  endtask

  task automatic checkModel(input string tag);
    logic [SW-1:0] eDout;
    eDout = (mq.size() > 0) ? mq[0] : '0;
    checkOutput({tag, ".level"}, 32'(level), 32'(mq.size()));
    checkOutput({tag, ".valid"}, 32'(out_valid), 32'(mq.size() > 0));
    checkOutput({tag, ".dout"}, 32'(dout), 32'(eDout));
    checkOutput({tag, ".full"}, 32'(full), 32'((CAP - mq.size()) < LANES));
    checkOutput({tag, ".ce"}, 32'(ce), 32'((CAP - mq.size()) >= CE_ROOM));
    checkOutput({tag, ".overflow"}, 32'(overflow), 32'(mOvf));
    checkOutput({tag, ".last"}, 32'(out_last), 32'((mq.size() > 0) && (mCnt == FRAME - 1)));
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, ".level"}, 32'(level), 32'(0));
    checkOutput({tag, ".valid"}, 32'(out_valid), 32'(0));
    checkOutput({tag, ".dout"}, 32'(dout), 32'(0));
    checkOutput({tag, ".last"}, 32'(out_last), 32'(0));
    checkOutput({tag, ".full"}, 32'(full), 32'(0));
    checkOutput({tag, ".ce"}, 32'(ce), 32'(1));
    checkOutput({tag, ".overflow"}, 32'(overflow), 32'(0));
  endtask

  // Streams nSamples tagged with their own index; stalls the reader for 10 cycles
  // once stallAt samples have been read. Starts from an empty buffer at frame index 0.
  task automatic streamRun(input int nSamples, input int stallAt, input string tag);
    int rdCount, wIdx, stallLeft, lastHits;
    bit stallDone, hs;
    logic rdy, doWr;
    logic [DW-1:0] word;
    rdCount = 0; wIdx = 0; stallLeft = 0; lastHits = 0; stallDone = 1'b0;
    for (int cyc = 0; cyc < nSamples * 4 + 50 && rdCount < nSamples; cyc++) begin
      if (rdCount == stallAt && !stallDone) begin
        stallLeft = 10;
        stallDone = 1'b1;
      end
      rdy  = (stallLeft == 0);
      doWr = (wIdx * LANES < nSamples) && ((CAP - mq.size()) >= LANES);
      word = {SW'(wIdx * 2), SW'(wIdx * 2 + 1)};
      hs   = rdy && (mq.size() > 0);
      applyStimulus(1'b0, doWr, doWr ? word : '0, rdy);
      if (doWr) wIdx++;
      if (hs) rdCount++;
      if (stallLeft > 0) stallLeft--;
      checkModel(tag);
      if (mq.size() > 0) begin
        checkOutput({tag, ".seq"}, 32'(dout), 32'(SW'(rdCount)));
        checkOutput({tag, ".lastIdx"}, 32'(out_last), 32'((rdCount % FRAME) == FRAME - 1));
        if (out_last === 1'b1 && rdy) lastHits++;
      end
    end
    vectorCount++;
    if (rdCount < nSamples) begin
      miscompareCount++;
      $display("[TB] FAIL %s.timeout: read %0d samples, required %0d", tag, rdCount, nSamples);
    end
    checkOutput({tag, ".lastCount"}, 32'(lastHits), 32'(nSamples / FRAME));
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, miscompares so far %0d", miscompareCount);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] rnd;
    logic rc, rw, rr;

    // Write two words then drain with the reader always ready.
    addVec(0, 1, {A, B}, 1, 2, 1, A, 0, 1, 0);
    addVec(0, 1, {C, D}, 1, 3, 1, B, 0, 1, 0);
    addVec(0, 0, '0,     1, 2, 1, C, 0, 1, 0);
    addVec(0, 0, '0,     1, 1, 1, D, 0, 1, 0);
    addVec(0, 0, '0,     1, 0, 0, '0, 0, 1, 0);
    // Fill to capacity with the reader stalled, then one dropped write.
    for (int k = 0; k < 8; k++)
      addVec(0, 1, {sVal(22'h100000, 2*k), sVal(22'h100000, 2*k+1)}, 0,
             2*(k+1), 1, sVal(22'h100000, 0), (k == 7), ((CAP - 2*(k+1)) >= CE_ROOM), 0);
    addVec(0, 1, {22'h3FFFFF, 22'h3FFFFE}, 0, 16, 1, sVal(22'h100000, 0), 1, 0, 1);
    // Drain down to level 5.
    for (int j = 1; j <= 11; j++)
      addVec(0, 0, '0, 1, 16 - j, 1, sVal(22'h100000, j), (j < 2), (j >= 6), 1);
    // Simultaneous write and read at level 5, then drain across the pointer wrap.
    addVec(0, 1, {N0, N1}, 1, 6, 1, sVal(22'h100000, 12), 0, 1, 1);
    addVec(0, 0, '0, 1, 5, 1, sVal(22'h100000, 13), 0, 1, 1);
    addVec(0, 0, '0, 1, 4, 1, sVal(22'h100000, 14), 0, 1, 1);
    addVec(0, 0, '0, 1, 3, 1, sVal(22'h100000, 15), 0, 1, 1);
    addVec(0, 0, '0, 1, 2, 1, N0, 0, 1, 1);
    addVec(0, 0, '0, 1, 1, 1, N1, 0, 1, 1);
    addVec(0, 0, '0, 1, 0, 0, '0, 0, 1, 1);
    // Build level 9 with overflow still set, then clr beating a write and a read.
    for (int k = 0; k < 5; k++)
      addVec(0, 1, {sVal(22'h300000, 2*k), sVal(22'h300000, 2*k+1)}, 0,
             2*(k+1), 1, sVal(22'h300000, 0), 0, 1, 1);
    addVec(0, 0, '0, 1, 9, 1, sVal(22'h300000, 1), 0, 1, 1);
    addVec(1, 1, {C, D}, 1, 0, 0, '0, 0, 1, 0);
    addVec(0, 1, {A, B}, 0, 2, 1, A, 0, 1, 0);
    addVec(1, 0, '0, 0, 0, 0, '0, 0, 1, 0);

    #12;
    checkReset("reset");
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    modelReset();
    applyStimulus(0, 0, '0, 0);
    checkModel("idle");

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].c, vecs[i].w, vecs[i].d, vecs[i].r);
      checkOutput($sformatf("vec%0d.level", i), 32'(level), 32'(vecs[i].expLevel));
      checkOutput($sformatf("vec%0d.valid", i), 32'(out_valid), 32'(vecs[i].expValid));
      checkOutput($sformatf("vec%0d.dout", i), 32'(dout), 32'(vecs[i].expDout));
      checkOutput($sformatf("vec%0d.full", i), 32'(full), 32'(vecs[i].expFull));
      checkOutput($sformatf("vec%0d.ce", i), 32'(ce), 32'(vecs[i].expCe));
      checkOutput($sformatf("vec%0d.overflow", i), 32'(overflow), 32'(vecs[i].expOvf));
      checkOutput($sformatf("vec%0d.last", i), 32'(out_last), 32'(0));
    end

    $display("[TB] streaming two frames with a mid-stream stall");
    streamRun(128, 40, "stream");

    $display("[TB] reset pulse in the middle of a frame");
    streamRun(20, -1, "prefix");
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 1, {sVal(22'h0AAAAA, 2*k), sVal(22'h0AAAAA, 2*k+1)}, 0);
      checkModel("preReset");
    end
    clr = 1'b0; wr_valid = 1'b0; out_ready = 1'b0; din = '0;
    RST_N = 1'b0;
    #2;
    checkReset("rstPulse");
    modelReset();
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    applyStimulus(0, 1, {A, B}, 1);
    checkOutput("releaseEdge.level", 32'(level), 32'(0));
    checkModel("releaseEdge");
    streamRun(64, -1, "postReset");

    $display("[TB] random traffic against the queue model");
    for (int n = 0; n < 600; n++) begin
      rnd = {$urandom(), $urandom()};
      rc  = ($urandom_range(0, 39) == 0);
      rw  = ($urandom_range(0, 1) == 1);
      rr  = ($urandom_range(0, 2) != 0);
      applyStimulus(rc, rw, rnd[DW-1:0], rr);
      checkModel("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
    $finish;
  end

endmodule
